// File: rtl/mips_decode_if.sv
// Fetch-side and execute-side handshake bundle of the MIPS decode stage.
// The stage connects through the slave modport; its environment uses master.
interface mips_decode_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) ();
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [PC_W-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [PC_W-1:0]          out_pc;
  logic [4:0]               out_rs;
  logic [4:0]               out_rt;
  logic [4:0]               out_wr_reg;
  logic                     out_reg_write;
  logic                     out_is_load;
  logic                     out_is_store;
  logic [5:0]               out_opcode;
  logic [5:0]               out_funct;
  logic [4:0]               out_shamt;
  logic signed [DATA_W-1:0] out_imm;
  logic [CNT_W-1:0]         stall_count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs, out_rt, out_wr_reg,
           out_reg_write, out_is_load, out_is_store, out_opcode,
           out_funct, out_shamt, out_imm, stall_count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs, out_rt, out_wr_reg,
           out_reg_write, out_is_load, out_is_store, out_opcode,
           out_funct, out_shamt, out_imm, stall_count
  );
endinterface

// File: rtl/mips_decode_stage.sv
// Registered MIPS instruction-decode stage with valid/ready handshakes,
// load-use hazard detection (one bubble per hazard) and a saturating stall counter.
module mips_decode_stage #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16,
  parameter int LINK_REG = 31
) (
  input logic         clk,
  input logic         rst,
  mips_decode_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [4:0] LINK     = LINK_REG[4:0];

  function automatic logic signed [DATA_W-1:0] ext_imm(input logic [5:0] op,
                                                       input logic [15:0] imm16);
    logic signed [31:0] lui_val;
    lui_val = {imm16, 16'b0};
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: ext_imm = DATA_W'(imm16);
      OP_LUI:                   ext_imm = DATA_W'(lui_val);
      default:                  ext_imm = DATA_W'($signed(imm16));
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [5:0]               opcode_p0, funct_p0;
  logic [4:0]               rs_p0, rt_p0, rd_p0, shamt_p0, dest_p0, wr_reg_p0;
  logic                     reg_write_p0, is_load_p0, is_store_p0, rt_read_p0;
  logic signed [DATA_W-1:0] imm_p0;

  logic                     vld_p1;
  logic [PC_W-1:0]          pc_p1;
  logic [5:0]               opcode_p1, funct_p1;
  logic [4:0]               rs_p1, rt_p1, wr_reg_p1, shamt_p1;
  logic                     reg_write_p1, is_load_p1, is_store_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [CNT_W-1:0]         stall_cnt_p1;

  logic hazard, in_ready, accept;

  // Stage p0: combinational decode of the incoming instruction word
  assign opcode_p0   = bus.in_instr[31:26];
  assign rs_p0       = bus.in_instr[25:21];
  assign rt_p0       = bus.in_instr[20:16];
  assign rd_p0       = bus.in_instr[15:11];
  assign shamt_p0    = bus.in_instr[10:6];
  assign funct_p0    = bus.in_instr[5:0];
  assign is_load_p0  = (opcode_p0 == OP_LW);
  assign is_store_p0 = (opcode_p0 == OP_SW);
  assign rt_read_p0  = (opcode_p0 == OP_RTYPE) || (opcode_p0 == OP_BEQ) ||
                       (opcode_p0 == OP_BNE)   || (opcode_p0 == OP_SW);
  assign imm_p0      = ext_imm(opcode_p0, bus.in_instr[15:0]);

  always_comb begin
    reg_write_p0 = 1'b0;
    dest_p0      = rt_p0;
    case (opcode_p0)
      OP_RTYPE: begin
        reg_write_p0 = (funct_p0 != FN_JR);
        dest_p0      = rd_p0;
      end
      OP_JAL: begin
        reg_write_p0 = 1'b1;
        dest_p0      = LINK;
      end
      OP_LW:   reg_write_p0 = 1'b1;
      default: reg_write_p0 = (opcode_p0[5:3] == 3'b001);
    endcase
    wr_reg_p0 = reg_write_p0 ? dest_p0 : 5'd0;
  end

  // A held load blocks any incoming instruction that reads its destination
  assign hazard = vld_p1 && is_load_p1 && (wr_reg_p1 != 5'd0) &&
                  ((rs_p0 == wr_reg_p1) || (rt_read_p0 && (rt_p0 == wr_reg_p1)));

  assign in_ready = (!vld_p1 || bus.out_ready) && !hazard && !bus.flush && !rst;
  assign accept   = bus.in_valid && in_ready;

  // Stage p1: single output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      wr_reg_p1    <= '0;
      reg_write_p1 <= 1'b0;
      is_load_p1   <= 1'b0;
      is_store_p1  <= 1'b0;
      opcode_p1    <= '0;
      funct_p1     <= '0;
      shamt_p1     <= '0;
      imm_p1       <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      if (bus.flush) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1       <= 1'b1;
        pc_p1        <= bus.in_pc;
        rs_p1        <= rs_p0;
        rt_p1        <= rt_p0;
        wr_reg_p1    <= wr_reg_p0;
        reg_write_p1 <= reg_write_p0;
        is_load_p1   <= is_load_p0;
        is_store_p1  <= is_store_p0;
        opcode_p1    <= opcode_p0;
        funct_p1     <= funct_p0;
        shamt_p1     <= shamt_p0;
        imm_p1       <= imm_p0;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (bus.in_valid && hazard && !bus.flush)
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = vld_p1;
  assign bus.out_pc        = pc_p1;
  assign bus.out_rs        = rs_p1;
  assign bus.out_rt        = rt_p1;
  assign bus.out_wr_reg    = wr_reg_p1;
  assign bus.out_reg_write = reg_write_p1;
  assign bus.out_is_load   = is_load_p1;
  assign bus.out_is_store  = is_store_p1;
  assign bus.out_opcode    = opcode_p1;
  assign bus.out_funct     = funct_p1;
  assign bus.out_shamt     = shamt_p1;
  assign bus.out_imm       = imm_p1;
  assign bus.stall_count   = stall_cnt_p1;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: directed scenarios plus random traffic against a
// transaction-level model; a second instance with a 2-bit counter exercises saturation.
module tb_mips_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_decode_if #(.DATA_W(32), .PC_W(32), .CNT_W(16)) bus ();
  mips_decode_if #(.DATA_W(32), .PC_W(32), .CNT_W(2))  bus2 ();

  mips_decode_stage #(.DATA_W(32), .PC_W(32), .CNT_W(16), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  mips_decode_stage #(.DATA_W(32), .PC_W(32), .CNT_W(2), .LINK_REG(31)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  assign bus2.flush     = bus.flush;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.in_pc     = bus.in_pc;
  assign bus2.out_ready = bus.out_ready;

  typedef struct packed {
    logic [4:0]  rs, rt, wr;
    logic        rw, ld, st;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] imm, pc;
  } dec_t;

  int   checks = 0, failures = 0;
  logic m_vld;
  dec_t m_ent;
  int   m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decoded view of an instruction, straight from the ISA field rules
  function automatic dec_t model_decode(input logic [31:0] instr, input logic [31:0] pc);
    dec_t d;
    int op, fn, imm16;
    op = int'(instr[31:26]);
    fn = int'(instr[5:0]);
    imm16 = int'(instr[15:0]);
    d.rs = instr[25:21];
    d.rt = instr[20:16];
    d.op = instr[31:26];
    d.fn = instr[5:0];
    d.sh = instr[10:6];
    d.pc = pc;
    d.ld = (op == 35);
    d.st = (op == 43);
    d.rw = (op == 0 && fn != 8) || (op >= 8 && op <= 15) || op == 35 || op == 3;
    if (!d.rw)        d.wr = 5'd0;
    else if (op == 0) d.wr = instr[15:11];
    else if (op == 3) d.wr = 5'd31;
    else              d.wr = instr[20:16];
    if (op >= 12 && op <= 14)  d.imm = imm16;
    else if (op == 15)         d.imm = imm16 * 65536;
    else if (imm16 >= 32768)   d.imm = imm16 - 65536;
    else                       d.imm = imm16;
    return d;
  endfunction

  function automatic logic model_hazard(input logic [31:0] instr);
    dec_t d;
    logic reads_rt;
    d = model_decode(instr, 32'd0);
    reads_rt = (d.op == 0) || (d.op == 4) || (d.op == 5) || (d.op == 43);
    return m_vld && m_ent.ld && (m_ent.wr != 0) &&
           ((d.rs == m_ent.wr) || (reads_rt && d.rt == m_ent.wr));
  endfunction

  // One clock: drive, check against the model, clock, advance the model
  task automatic step(input logic f, input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic ordy, output logic acc);
    logic haz, exp_rdy;
    bus.flush = f; bus.in_valid = v; bus.in_instr = instr; bus.in_pc = pc;
    bus.out_ready = ordy;
    #1;
    haz = model_hazard(instr);
    exp_rdy = (!m_vld || ordy) && !haz && !f && !rst;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
    chk("fields", {bus.out_rs, bus.out_rt, bus.out_wr_reg, bus.out_reg_write,
                   bus.out_is_load, bus.out_is_store, bus.out_opcode,
                   bus.out_funct, bus.out_shamt},
                  {m_ent.rs, m_ent.rt, m_ent.wr, m_ent.rw, m_ent.ld, m_ent.st,
                   m_ent.op, m_ent.fn, m_ent.sh});
    chk("imm", 64'($unsigned(bus.out_imm)), 64'(m_ent.imm));
    chk("pc", 64'(bus.out_pc), 64'(m_ent.pc));
    chk("stall_count", 64'(bus.stall_count), 64'(m_cnt));
    chk("stall_sat", 64'(bus2.stall_count), 64'(m_cnt2));
    acc = v && exp_rdy;
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0; m_ent = '0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (v && haz && !f) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (f) m_vld = 1'b0;
      else if (acc) begin m_vld = 1'b1; m_ent = model_decode(instr, pc); end
      else if (ordy) m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] ADD_I  = 32'h00221820;
  localparam logic [31:0] JAL_I  = 32'h0C000010;
  localparam logic [31:0] LW_I   = 32'h8C250004;
  localparam logic [31:0] ADD2_I = 32'h00A23020;
  localparam logic [31:0] ADDI_I = 32'h2002FFFF;
  localparam logic [31:0] ORI_I  = 32'h3402FFFF;
  localparam logic [31:0] LUI_I  = 32'h3C021234;
  localparam logic [31:0] SW_I   = 32'hAC250004;

  initial begin
    logic acc;
    int n;
    logic [31:0] held_pc, held_imm;
    logic [31:0] ops [12];
    ops = '{32'd0, 32'd3, 32'd35, 32'd43, 32'd4, 32'd5, 32'd2, 32'd8,
            32'd12, 32'd13, 32'd15, 32'd35};
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0;
    m_vld = 1'b0; m_ent = '0; m_cnt = 0; m_cnt2 = 0;
    @(posedge clk);
    @(negedge clk);
    step(0, 0, 0, 0, 0, acc);
    step(0, 1, ADD_I, 0, 1, acc);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1 chk("release_in_ready", 64'(bus.in_ready), 64'd1);

    step(0, 1, ADD_I, 32'h100, 1, acc);
    chk("add_rs", 64'(bus.out_rs), 64'd1);
    chk("add_rt", 64'(bus.out_rt), 64'd2);
    chk("add_wr", 64'(bus.out_wr_reg), 64'd3);
    chk("add_rw", 64'(bus.out_reg_write), 64'd1);
    step(0, 1, JAL_I, 32'h104, 1, acc);
    chk("jal_valid", 64'(bus.out_valid), 64'd1);
    chk("jal_pc", 64'(bus.out_pc), 64'h104);
    chk("jal_wr", 64'(bus.out_wr_reg), 64'd31);
    chk("jal_rw", 64'(bus.out_reg_write), 64'd1);

    step(0, 1, LW_I, 32'h108, 1, acc);
    chk("lw_load", 64'(bus.out_is_load), 64'd1);
    chk("lw_wr", 64'(bus.out_wr_reg), 64'd5);
    chk("lw_imm", 64'($unsigned(bus.out_imm)), 64'h4);
    n = 0;
    do begin
      step(0, 1, ADD2_I, 32'h10C, 1, acc);
      n++;
      if (n == 1) chk("bubble", 64'(bus.out_valid), 64'd0);
    end while (!acc && n < 8);
    chk("dep_cycles", 64'(n), 64'd2);
    chk("dep_wr", 64'(bus.out_wr_reg), 64'd6);
    chk("stall_one", 64'(bus.stall_count), 64'd1);

    step(0, 1, ADDI_I, 32'h110, 1, acc);
    chk("addi_imm", 64'($unsigned(bus.out_imm)), 64'hFFFFFFFF);
    step(0, 1, ORI_I, 32'h114, 1, acc);
    chk("ori_imm", 64'($unsigned(bus.out_imm)), 64'h0000FFFF);
    step(0, 1, LUI_I, 32'h118, 1, acc);
    chk("lui_imm", 64'($unsigned(bus.out_imm)), 64'h12340000);
    step(0, 1, SW_I, 32'h11C, 1, acc);
    chk("sw_store", 64'(bus.out_is_store), 64'd1);
    chk("sw_rw", 64'(bus.out_reg_write), 64'd0);
    chk("sw_wr", 64'(bus.out_wr_reg), 64'd0);

    held_pc = bus.out_pc;
    held_imm = bus.out_imm;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, ADD_I, 32'h120, 0, acc);
      chk("bp_pc_stable", 64'(bus.out_pc), 64'(held_pc));
      chk("bp_imm_stable", 64'($unsigned(bus.out_imm)), 64'(held_imm));
    end
    step(0, 1, ADD_I, 32'h120, 1, acc);
    chk("bp_release_pc", 64'(bus.out_pc), 64'h120);

    step(0, 1, LW_I, 32'h124, 1, acc);
    step(0, 1, ADD2_I, 32'h128, 0, acc);
    chk("flush_pre_stall", 64'(bus.stall_count), 64'd2);
    step(1, 1, ADD2_I, 32'h128, 0, acc);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_stall", 64'(bus.stall_count), 64'd2);
    step(0, 1, ADD2_I, 32'h128, 0, acc);
    chk("flush_no_bubble", 64'(bus.out_valid), 64'd1);
    chk("flush_pc", 64'(bus.out_pc), 64'h128);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] instr;
      instr = {ops[$urandom_range(0, 11)][5:0], 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 16'($urandom)};
      if ($urandom_range(0, 7) == 0) instr[5:0] = 6'b001000;
      rst = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), instr,
           $urandom, ($urandom_range(0, 3) != 0), acc);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
Registered, handshaked instruction-decode stage for the 32-bit MIPS core. It is the parametrised successor of the single-cycle field-extraction decoder. It extracts register fields and selects the destination register, covering R-type, I-type and jal. It also generates the extended immediate and the write/load/store flags, detects load-use hazards and inserts exactly one bubble for each. It sits between the fetch stage (valid/ready upstream) and register-read/execute (valid/ready downstream).

Parameters:
DATA_W, 32, width of the extended immediate; must be >= 32.
PC_W, 32, width of the PC carried alongside the instruction.
CNT_W, 16, width of the saturating stall counter.
LINK_REG, 31, destination register for jal.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
flush  in  1  synchronous kill of the held instruction.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage accepts in_instr this cycle.
in_instr  in  32  instruction word.
in_pc  in  PC_W  PC of in_instr.
out_valid  out  1  decoded entry valid.
out_ready  in  1  downstream accepts the entry.
out_pc  out  PC_W  PC of the held entry.
out_rs, out_rt  out  5  instr[25:21], instr[20:16].
out_wr_reg  out  5  destination register; 0 when out_reg_write=0.
out_reg_write  out  1  instruction writes the register file.
out_is_load, out_is_store  out  1  opcode 100011 / 101011.
out_opcode  out  6  instr[31:26].
out_funct  out  6  instr[5:0].
out_shamt  out  5  instr[10:6].
out_imm  out  DATA_W  extended immediate.
stall_count  out  CNT_W  number of load-use bubble cycles.

Behaviour:
- Reset (rst=1 at clk edge): every output register goes to 0 and out_valid=0. in_ready is forced to 0 while rst=1. rst has priority over flush and over the handshake.
- Single output register; latency is 1 cycle from acceptance to out_valid.
- Acceptance condition: in_valid & in_ready.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~rst.
- Transfer out on out_valid & out_ready. Load the register on accept. If the entry transfers out with no accept in the same cycle, clear out_valid.
- Accept and drain may happen in the same cycle; this gives full throughput.
- All out_* fields remain stable while out_valid=1 & out_ready=0.
- Destination select:
  - opcode 000000: rd = instr[15:11].
  - opcode 000011 (jal): LINK_REG.
  - All other opcodes: rt.
- out_reg_write = 1 for:
  - R-type, except funct 001000 (jr);
  - opcodes 001xxx;
  - opcode 100011;
  - opcode 000011.
- out_reg_write = 0 otherwise (sw, beq 000100, bne 000101, j 000010, jr). When out_reg_write=0, out_wr_reg is forced to 0.
- Immediate extension:
  - andi 001100, ori 001101, xori 001110: zero-extend instr[15:0].
  - lui 001111: {instr[15:0], 16'b0}, sign-extended to DATA_W.
  - All other opcodes: sign-extend instr[15:0].
- Source usage: rs is always treated as read. rt is read for R-type, beq, bne and sw.
- hazard = out_valid & out_is_load & (out_wr_reg != 0) & ((in rs == out_wr_reg) | (rt-read & in rt == out_wr_reg)).
  - hazard is evaluated combinationally on in_instr.
  - While hazard=1, the dependent instruction is not accepted. When the load drains, out_valid drops for exactly one cycle (the bubble). The dependent instruction is accepted on the following cycle.
- stall_count increments in every cycle where in_valid & hazard. It saturates at 2^CNT_W-1 and resets only on rst.
- flush=1: out_valid is cleared at the edge and no accept occurs that cycle. stall_count is not incremented during flush.
- A flush arriving mid-hazard discards the load; the waiting instruction is accepted on the next cycle with no bubble.

Test Plan:
- Reset with rst=1 for 2 cycles → all outputs 0, in_ready=0. On release with out_valid=0 → in_ready=1.
- Send add $3,$1,$2 (0x00221820), then jal (0x0C000010), back-to-back with out_ready=1:
  - add → rs=1, rt=2, wr=3, reg_write=1.
  - jal → wr=31, reg_write=1.
  - One instruction is delivered per cycle.
- Send lw $5,4($1) (0x8C250004) then add $6,$5,$2 (0x00A23020):
  - lw → is_load=1, wr=5, imm=0x00000004.
  - The add waits; exactly one cycle with out_valid=0 separates the two outputs; stall_count=1.
- Immediate checks:
  - addi $2,$0,-1 (0x2002FFFF) → imm=0xFFFFFFFF.
  - ori (0x3402FFFF) → imm=0x0000FFFF.
  - lui (0x3C021234) → imm=0x12340000.
  - sw (0xAC250004) → is_store=1, reg_write=0, wr=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → out_* stable and in_ready=0. Raise out_ready → the held entry transfers and the next instruction loads in the same cycle.
- Assert flush while a lw is held and a dependent add waits → out_valid=0 next cycle. The add is accepted the following cycle with no bubble; stall_count is unchanged during the flush.
